// File: rtl/shift_add_mul.sv
// Sequential shift-and-add multiplier with start/busy/done handshake.
// Signed operands are multiplied as magnitudes and the sign is applied on exit.
module shift_add_mul #(
    parameter int unsigned WIDTH      = 16,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [PW-1:0]    product_q, product_d;
    logic [WIDTH-1:0] a_mag, b_mag;

    // Operand magnitudes; the most negative value maps onto itself, which is correct unsigned.
    always_comb begin
        a_mag = a;
        b_mag = b;
        if (signed_mode && a[WIDTH-1]) a_mag = WIDTH'(0) - a;
        if (signed_mode && b[WIDTH-1]) b_mag = WIDTH'(0) - b;
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_CALC;
                    mcand_d  = PW'(a_mag);
                    mplier_d = b_mag;
                    acc_d    = '0;
                    cnt_d    = CW'(WIDTH);
                    neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    busy_d   = 1'b1;
                end
            end
            S_CALC: begin
                acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                // Exit test uses the post-step counter and multiplier.
                if (cnt_d == '0 || (EARLY_EXIT && mplier_d == '0)) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    product_d = neg_q ? PW'(0) - acc_d : acc_d;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
